// File: rtl/spike_aer_encoder.sv
// sync_fifo: generic single-clock FIFO with reset-cleared storage and a held read port.
// Latency: a pushed entry is visible on pop_dat the cycle after the push edge.
// Backpressure: the writer must not push when count == DEPTH; pop_rdy while empty is ignored.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_vld,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop_rdy,
    output logic                     pop_vld,
    output logic [W-1:0]             pop_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [W-1:0]     last_dat;
    logic             pop;

    assign pop_vld = (count != '0);
    assign pop     = pop_rdy && pop_vld;
    // When empty, keep presenting the most recently popped entry.
    assign pop_dat = pop_vld ? mem[rd_ptr] : last_dat;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            last_dat <= '0;
        end else begin
            if (push_vld) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + PTR_W'(1);
                last_dat <= mem[rd_ptr];
            end
            case ({push_vld, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// spike_aer_encoder: round-robin arbiter turning neuron spike pulses into {addr, ts} AER events.
// Latency: spike sampled at edge k, granted and pushed at edge k+1, aer_valid after edge k+1.
// Backpressure: full FIFO stalls grants; one event per neuron waits in pending, extra spikes drop and set overflow.
module spike_aer_encoder #(
    parameter int N_NEURONS  = 8,
    parameter int ADDR_W     = 3,
    parameter int TS_W       = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_NEURONS-1:0]          spike_in,
    output logic                          aer_valid,
    input  logic                          aer_ready,
    output logic [ADDR_W-1:0]             aer_addr,
    output logic [TS_W-1:0]               aer_ts,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    input  logic                          clear_overflow
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W:0]   N_EXT  = (ADDR_W + 1)'(N_NEURONS);
    localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(N_NEURONS - 1);
    localparam logic [CNT_W-1:0]  FULL_C = CNT_W'(FIFO_DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [TS_W-1:0]   ts;
    } aer_evt_t;

    logic [N_NEURONS-1:0]   pending;
    logic [ADDR_W-1:0]      rr_ptr;
    logic [TS_W-1:0]        ts_cnt;

    logic [2*N_NEURONS-1:0] pend_dbl;
    logic [N_NEURONS-1:0]   pend_rot;
    logic                   found;
    logic [ADDR_W-1:0]      grant_off;
    logic [ADDR_W:0]        win_sum;
    logic [ADDR_W-1:0]      win_idx;
    logic                   grant_vld;
    logic [N_NEURONS-1:0]   grant_vec;
    logic                   drop;

    aer_evt_t               push_evt;
    aer_evt_t               head_evt;

    // Rotate pending so bit 0 of pend_rot is the neuron at rr_ptr.
    assign pend_dbl = {pending, pending};
    assign pend_rot = pend_dbl[rr_ptr +: N_NEURONS];

    always_comb begin
        found     = 1'b0;
        grant_off = '0;
        for (int j = 0; j < N_NEURONS; j++) begin
            if (!found && pend_rot[j]) begin
                found     = 1'b1;
                grant_off = ADDR_W'(j);
            end
        end
        win_sum = {1'b0, rr_ptr} + {1'b0, grant_off};
        win_idx = (win_sum >= N_EXT) ? ADDR_W'(win_sum - N_EXT) : ADDR_W'(win_sum);
    end

    // Full is judged on the registered count, so a same-cycle pop never frees a slot for a grant.
    assign grant_vld = found && (fifo_count != FULL_C);
    assign grant_vec = grant_vld ? (N_NEURONS'(1) << win_idx) : '0;
    assign drop      = |(pending & ~grant_vec & spike_in);

    assign push_evt.addr = win_idx;
    assign push_evt.ts   = ts_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending  <= '0;
            rr_ptr   <= '0;
            ts_cnt   <= '0;
            overflow <= 1'b0;
        end else begin
            ts_cnt  <= ts_cnt + TS_W'(1);
            pending <= (pending & ~grant_vec) | spike_in;
            if (grant_vld) begin
                rr_ptr <= (win_idx == LAST) ? '0 : win_idx + ADDR_W'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (clear_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

    sync_fifo #(
        .W     (ADDR_W + TS_W),
        .DEPTH (FIFO_DEPTH)
    ) u_evt_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_vld (grant_vld),
        .push_dat (push_evt),
        .pop_rdy  (aer_ready),
        .pop_vld  (aer_valid),
        .pop_dat  (head_evt),
        .count    (fifo_count)
    );

    assign aer_addr = head_evt.addr;
    assign aer_ts   = head_evt.ts;
endmodule

// File: tb/tb_spike_aer_encoder.sv
// Directed bench for spike_aer_encoder: main instance with TS_W=16 plus a TS_W=4 instance for timestamp wrap.
module tb_spike_aer_encoder;
    logic        clk;
    logic        reset;
    logic [7:0]  spike_in;
    logic        aer_ready;
    logic        clear_overflow;

    logic        aer_valid;
    logic [2:0]  aer_addr;
    logic [15:0] aer_ts;
    logic [3:0]  fifo_count;
    logic        overflow;

    logic        aer_valid4;
    logic [2:0]  aer_addr4;
    logic [3:0]  aer_ts4;
    logic [3:0]  fifo_count4;
    logic        overflow4;

    int errors;
    int checks;

    spike_aer_encoder #(.N_NEURONS(8), .ADDR_W(3), .TS_W(16), .FIFO_DEPTH(8)) dut (
        .clk(clk), .reset(reset), .spike_in(spike_in), .aer_valid(aer_valid),
        .aer_ready(aer_ready), .aer_addr(aer_addr), .aer_ts(aer_ts),
        .fifo_count(fifo_count), .overflow(overflow), .clear_overflow(clear_overflow)
    );

    spike_aer_encoder #(.N_NEURONS(8), .ADDR_W(3), .TS_W(4), .FIFO_DEPTH(8)) dut4 (
        .clk(clk), .reset(reset), .spike_in(spike_in), .aer_valid(aer_valid4),
        .aer_ready(aer_ready), .aer_addr(aer_addr4), .aer_ts(aer_ts4),
        .fifo_count(fifo_count4), .overflow(overflow4), .clear_overflow(clear_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Returns at a falling edge just after release; ts_cnt is 0 in the current cycle.
    task automatic do_reset();
        reset          = 1'b1;
        spike_in       = '0;
        clear_overflow = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (aer_valid !== 1'b0) begin errors++; $display("FAIL reset aer_valid: got %0d want 0", aer_valid); end
        checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL reset fifo_count: got %0d want 0", fifo_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset overflow: got %0d want 0", overflow); end
        checks++; if (aer_addr !== 3'd0) begin errors++; $display("FAIL reset aer_addr: got %0d want 0", aer_addr); end
        checks++; if (aer_ts !== 16'd0) begin errors++; $display("FAIL reset aer_ts: got %0d want 0", aer_ts); end
    endtask

    task automatic test_single();
        do_reset();
        aer_ready = 1'b1;
        repeat (9) @(negedge clk);
        spike_in = 8'h20;
        @(negedge clk);
        spike_in = 8'h00;
        checks++; if (aer_valid !== 1'b0) begin errors++; $display("FAIL single early valid: got %0d want 0", aer_valid); end
        @(negedge clk);
        checks++; if (aer_valid !== 1'b1) begin errors++; $display("FAIL single valid: got %0d want 1", aer_valid); end
        checks++; if (aer_addr !== 3'd5) begin errors++; $display("FAIL single addr: got %0d want 5", aer_addr); end
        checks++; if (aer_ts !== 16'd10) begin errors++; $display("FAIL single ts: got %0d want 10", aer_ts); end
        checks++; if (fifo_count !== 4'd1) begin errors++; $display("FAIL single count: got %0d want 1", fifo_count); end
        @(negedge clk);
        checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL single drained count: got %0d want 0", fifo_count); end
        checks++; if (aer_addr !== 3'd5) begin errors++; $display("FAIL single held addr: got %0d want 5", aer_addr); end
    endtask

    task automatic test_all_neurons();
        do_reset();
        aer_ready = 1'b1;
        spike_in  = 8'hFF;
        @(negedge clk);
        spike_in = 8'h00;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            checks++; if (aer_valid !== 1'b1) begin errors++; $display("FAIL all valid[%0d]: got %0d want 1", j, aer_valid); end
            checks++; if (aer_addr !== 3'(j)) begin errors++; $display("FAIL all addr[%0d]: got %0d want %0d", j, aer_addr, j); end
            checks++; if (aer_ts !== 16'(j + 1)) begin errors++; $display("FAIL all ts[%0d]: got %0d want %0d", j, aer_ts, j + 1); end
        end
        @(negedge clk);
        checks++; if (aer_valid !== 1'b0) begin errors++; $display("FAIL all final valid: got %0d want 0", aer_valid); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL all overflow: got %0d want 0", overflow); end
    endtask

    task automatic test_round_robin();
        do_reset();
        aer_ready = 1'b1;
        spike_in  = 8'h03;
        @(negedge clk);
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            checks++; if (aer_addr !== 3'(j % 2)) begin errors++; $display("FAIL rr addr[%0d]: got %0d want %0d", j, aer_addr, j % 2); end
            checks++; if (aer_ts !== 16'(j + 1)) begin errors++; $display("FAIL rr ts[%0d]: got %0d want %0d", j, aer_ts, j + 1); end
            if (j == 0) begin
                checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL rr overflow: got %0d want 1", overflow); end
            end
        end
        spike_in = 8'h00;
    endtask

    task automatic test_backpressure();
        int exp_addr;
        int exp_ts;
        do_reset();
        aer_ready = 1'b0;
        spike_in  = 8'hFF;
        @(negedge clk);
        spike_in = 8'h0F;
        @(negedge clk);
        spike_in = 8'h00;
        repeat (7) @(negedge clk);
        checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL bp full count: got %0d want 8", fifo_count); end
        checks++; if (aer_addr !== 3'd0 || aer_ts !== 16'd1) begin errors++; $display("FAIL bp head: got %0d/%0d want 0/1", aer_addr, aer_ts); end
        repeat (3) @(negedge clk);
        checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL bp held count: got %0d want 8", fifo_count); end
        checks++; if (aer_valid !== 1'b1 || aer_addr !== 3'd0 || aer_ts !== 16'd1) begin errors++; $display("FAIL bp stable head: got v%0d %0d/%0d want v1 0/1", aer_valid, aer_addr, aer_ts); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp overflow: got %0d want 1", overflow); end
        aer_ready = 1'b1;
        // Full at ts 12 blocks neuron 0; it is granted at ts 13 after the first pop.
        for (int k = 1; k <= 8; k++) begin
            exp_addr = (k < 8) ? k : 0;
            exp_ts   = (k < 8) ? k + 1 : 13;
            @(negedge clk);
            checks++; if (aer_addr !== 3'(exp_addr) || aer_ts !== 16'(exp_ts)) begin errors++; $display("FAIL bp drain[%0d]: got %0d/%0d want %0d/%0d", k, aer_addr, aer_ts, exp_addr, exp_ts); end
        end
        @(negedge clk);
        checks++; if (aer_valid !== 1'b0 || fifo_count !== 4'd0) begin errors++; $display("FAIL bp empty: got v%0d c%0d want v0 c0", aer_valid, fifo_count); end
    endtask

    task automatic test_overflow_clear();
        do_reset();
        aer_ready = 1'b1;
        spike_in  = 8'h0C;
        @(negedge clk);
        spike_in       = 8'h08;
        clear_overflow = 1'b1;
        @(negedge clk);
        spike_in       = 8'h00;
        clear_overflow = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf set-over-clear: got %0d want 1", overflow); end
        @(negedge clk);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf sticky: got %0d want 1", overflow); end
        clear_overflow = 1'b1;
        @(negedge clk);
        clear_overflow = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf cleared: got %0d want 0", overflow); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        aer_ready = 1'b0;
        spike_in  = 8'h07;
        @(negedge clk);
        spike_in = 8'hF2;
        @(negedge clk);
        spike_in = 8'h00;
        @(negedge clk);
        @(negedge clk);
        checks++; if (fifo_count !== 4'd3) begin errors++; $display("FAIL mid pre count: got %0d want 3", fifo_count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL mid pre overflow: got %0d want 1", overflow); end
        reset = 1'b1;
        #1;
        checks++; if (aer_valid !== 1'b0 || fifo_count !== 4'd0 || overflow !== 1'b0) begin errors++; $display("FAIL mid reset flags: got v%0d c%0d o%0d want 0 0 0", aer_valid, fifo_count, overflow); end
        checks++; if (aer_addr !== 3'd0 || aer_ts !== 16'd0) begin errors++; $display("FAIL mid reset head: got %0d/%0d want 0/0", aer_addr, aer_ts); end
        @(negedge clk);
        reset     = 1'b0;
        aer_ready = 1'b1;
        spike_in  = 8'h40;
        @(negedge clk);
        spike_in = 8'h00;
        checks++; if (aer_valid !== 1'b0) begin errors++; $display("FAIL mid no stale event: got %0d want 0", aer_valid); end
        @(negedge clk);
        checks++; if (aer_valid !== 1'b1 || aer_addr !== 3'd6 || aer_ts !== 16'd1) begin errors++; $display("FAIL mid post event: got v%0d %0d/%0d want v1 6/1", aer_valid, aer_addr, aer_ts); end
        @(negedge clk);
        checks++; if (aer_valid !== 1'b0) begin errors++; $display("FAIL mid post drained: got %0d want 0", aer_valid); end
    endtask

    task automatic test_ts_wrap();
        do_reset();
        aer_ready = 1'b1;
        repeat (14) @(negedge clk);
        spike_in = 8'h08;
        @(negedge clk);
        @(negedge clk);
        spike_in = 8'h00;
        checks++; if (aer_valid4 !== 1'b1 || aer_addr4 !== 3'd3 || aer_ts4 !== 4'd15) begin errors++; $display("FAIL wrap first: got v%0d %0d/%0d want v1 3/15", aer_valid4, aer_addr4, aer_ts4); end
        @(negedge clk);
        checks++; if (aer_valid4 !== 1'b1 || aer_ts4 !== 4'd0) begin errors++; $display("FAIL wrap second: got v%0d ts%0d want v1 ts0", aer_valid4, aer_ts4); end
        checks++; if (aer_ts !== 16'd16) begin errors++; $display("FAIL wrap wide ts: got %0d want 16", aer_ts); end
        @(negedge clk);
        checks++; if (fifo_count4 !== 4'd0 || overflow4 !== 1'b0) begin errors++; $display("FAIL wrap end: got c%0d o%0d want c0 o0", fifo_count4, overflow4); end
    endtask

    initial begin
        errors         = 0;
        checks         = 0;
        reset          = 1'b1;
        spike_in       = '0;
        aer_ready      = 1'b0;
        clear_overflow = 1'b0;
        test_reset();
        test_single();
        test_all_neurons();
        test_round_robin();
        test_backpressure();
        test_overflow_clear();
        test_reset_mid();
        test_ts_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
